// File: rtl/dual_port_bus_memory.sv
// rtl/dual_port_bus_memory.sv - shared two-core word memory terminating multiplexed address/data buses
module dual_port_bus_memory #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Data_in0,
    input  logic              nALE0,
    input  logic              nME0,
    input  logic              RnW0,
    input  logic              nOE0,
    output logic [DATA_W-1:0] Data_out0,
    output logic              Data_oe0,
    output logic              Err0,
    input  logic [DATA_W-1:0] Data_in1,
    input  logic              nALE1,
    input  logic              nME1,
    input  logic              RnW1,
    input  logic              nOE1,
    output logic [DATA_W-1:0] Data_out1,
    output logic              Data_oe1,
    output logic              Err1
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    // Both cores share one array; port 0 is written last so it wins a same-address collision.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Per-port bus pins gathered into arrays so both access FSMs share one description.
    logic [DATA_W-1:0] w_din  [2];
    logic [1:0]        w_nale;
    logic [1:0]        w_nme;
    logic [1:0]        w_rnw;
    logic [1:0]        w_noe;

    state_t            r_state [2];
    state_t            w_next  [2];
    logic [ADDR_W-1:0] r_addr  [2];
    logic [DATA_W-1:0] r_dout  [2];
    logic [1:0]        r_err;

    logic [1:0]        w_rd_en;
    logic [1:0]        w_wr_en;
    logic [1:0]        w_err_set;
    logic [1:0]        w_addr_ld;

    assign w_din[0] = Data_in0;
    assign w_din[1] = Data_in1;
    assign w_nale   = {nALE1, nALE0};
    assign w_nme    = {nME1, nME0};
    assign w_rnw    = {RnW1, RnW0};
    assign w_noe    = {nOE1, nOE0};

    // Next-state and access decode; an address phase always overrides a concurrent data phase.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_next[p]    = r_state[p];
            w_rd_en[p]   = 1'b0;
            w_wr_en[p]   = 1'b0;
            w_err_set[p] = 1'b0;
            w_addr_ld[p] = 1'b0;
            if (!w_nale[p]) begin
                w_addr_ld[p] = 1'b1;
                w_next[p]    = ST_ADDR;
            end else if (!w_nme[p]) begin
                case (r_state[p])
                    ST_ADDR: begin
                        if (w_rnw[p]) begin
                            w_rd_en[p] = 1'b1;
                            w_next[p]  = ST_RD;
                        end else begin
                            w_wr_en[p] = 1'b1;
                            w_next[p]  = ST_WR;
                        end
                    end
                    ST_RD: begin
                        if (w_rnw[p]) begin
                            w_rd_en[p] = 1'b1;
                        end else begin
                            // Direction flip mid-burst: refuse the access and drop the burst.
                            w_err_set[p] = 1'b1;
                            w_next[p]    = ST_IDLE;
                        end
                    end
                    ST_WR: begin
                        if (!w_rnw[p]) begin
                            w_wr_en[p] = 1'b1;
                        end else begin
                            w_err_set[p] = 1'b1;
                            w_next[p]    = ST_IDLE;
                        end
                    end
                    default: begin
                        // Data phase without a latched address.
                        w_err_set[p] = 1'b1;
                    end
                endcase
            end else if (r_state[p] == ST_RD || r_state[p] == ST_WR) begin
                w_next[p] = ST_IDLE;
            end
        end
    end

    // Per-port state, address counter, read register and sticky error flag.
    always_ff @(posedge Clock) begin
        for (int p = 0; p < 2; p++) begin
            if (Reset) begin
                r_state[p] <= ST_IDLE;
                r_addr[p]  <= '0;
                r_dout[p]  <= '0;
                r_err[p]   <= 1'b0;
            end else begin
                r_state[p] <= w_next[p];
                if (w_addr_ld[p]) begin
                    r_addr[p] <= w_din[p][ADDR_W-1:0];
                    r_err[p]  <= 1'b0;
                end else if (w_rd_en[p] || w_wr_en[p]) begin
                    // Wraps modulo the depth at the top of the address space.
                    r_addr[p] <= r_addr[p] + ADDR_W'(1);
                end
                if (w_err_set[p]) begin
                    r_err[p] <= 1'b1;
                end
                if (w_rd_en[p]) begin
                    // Nonblocking read sees the pre-edge contents, giving read-before-write.
                    r_dout[p] <= r_mem[r_addr[p]];
                end
            end
        end
    end

    // RAM write ports; port 0 assigned last so its data lands on a shared address.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (w_wr_en[1]) begin
                r_mem[r_addr[1]] <= w_din[1];
            end
            if (w_wr_en[0]) begin
                r_mem[r_addr[0]] <= w_din[0];
            end
        end
    end

    assign Data_out0 = r_dout[0];
    assign Data_out1 = r_dout[1];
    assign Data_oe0  = (r_state[0] == ST_RD) & ~nOE0;
    assign Data_oe1  = (r_state[1] == ST_RD) & ~nOE1;
    assign Err0      = r_err[0];
    assign Err1      = r_err[1];

endmodule

// File: tb/tb_dual_port_bus_memory.sv
// tb/tb_dual_port_bus_memory.sv - vector table and read scoreboard bench for dual_port_bus_memory
module tb_dual_port_bus_memory;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [63:0] Data_in0, Data_in1;
    logic        nALE0, nME0, RnW0, nOE0;
    logic        nALE1, nME1, RnW1, nOE1;
    logic [63:0] Data_out0, Data_out1;
    logic        Data_oe0, Data_oe1, Err0, Err1;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];

    dual_port_bus_memory #(.DATA_W(64), .ADDR_W(10)) dut (
        .Clock(Clock), .Reset(Reset),
        .Data_in0(Data_in0), .nALE0(nALE0), .nME0(nME0), .RnW0(RnW0), .nOE0(nOE0),
        .Data_out0(Data_out0), .Data_oe0(Data_oe0), .Err0(Err0),
        .Data_in1(Data_in1), .nALE1(nALE1), .nME1(nME1), .RnW1(RnW1), .nOE1(nOE1),
        .Data_out1(Data_out1), .Data_oe1(Data_oe1), .Err1(Err1)
    );

    always #5 Clock = ~Clock;

    // pins = {nALE, nME, RnW, nOE}
    localparam logic [3:0] IDL = 4'b1111;
    localparam logic [3:0] ALE = 4'b0111;
    localparam logic [3:0] WRP = 4'b1001;
    localparam logic [3:0] RDP = 4'b1010;
    localparam logic [3:0] RDH = 4'b1011;
    localparam logic [3:0] HOE = 4'b1110;
    localparam logic [63:0] Z  = 64'h0;

    typedef struct {
        logic [3:0]  p0;
        logic [63:0] d0;
        logic [3:0]  p1;
        logic [63:0] d1;
        logic        rst;
        logic [1:0]  chk;   // {port0 data check, port1 data check}
        logic [63:0] e0;
        logic [63:0] e1;
        logic [3:0]  x;     // {oe0, oe1, err0, err1}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [3:0] p0, input logic [63:0] d0,
                               input logic [3:0] p1, input logic [63:0] d1,
                               input logic rst, input logic [1:0] chk,
                               input logic [63:0] e0, input logic [63:0] e1,
                               input logic [3:0] x);
        vec_t t;
        t.p0 = p0; t.d0 = d0; t.p1 = p1; t.d1 = d1; t.rst = rst;
        t.chk = chk; t.e0 = e0; t.e1 = e1; t.x = x;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        logic [63:0] e;
        {nALE0, nME0, RnW0, nOE0} = t.p0;
        {nALE1, nME1, RnW1, nOE1} = t.p1;
        Data_in0 = t.d0;
        Data_in1 = t.d1;
        Reset    = t.rst;
        if (t.chk[1]) q0.push_back(t.e0);
        if (t.chk[0]) q1.push_back(t.e1);
        @(posedge Clock);
        #1;
        check($sformatf("row%0d oe0", idx), {63'b0, Data_oe0}, {63'b0, t.x[3]});
        check($sformatf("row%0d oe1", idx), {63'b0, Data_oe1}, {63'b0, t.x[2]});
        check($sformatf("row%0d err0", idx), {63'b0, Err0}, {63'b0, t.x[1]});
        check($sformatf("row%0d err1", idx), {63'b0, Err1}, {63'b0, t.x[0]});
        if (t.chk[1]) begin
            e = q0.pop_front();
            check($sformatf("row%0d dout0", idx), Data_out0, e);
        end
        if (t.chk[0]) begin
            e = q1.pop_front();
            check($sformatf("row%0d dout1", idx), Data_out1, e);
        end
    endtask

    initial begin
        // reset
        tbl.push_back(v(IDL, Z, IDL, Z, 1'b1, 2'b11, Z, Z, 4'b0000));
        tbl.push_back(v(IDL, Z, IDL, Z, 1'b1, 2'b11, Z, Z, 4'b0000));
        // p0 write burst at 0x010, p1 reads it back with nOE toggling
        tbl.push_back(v(ALE, 64'h010, IDL, Z, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(WRP, 64'h0A, ALE, 64'h010, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(WRP, 64'h0B, RDP, Z, 1'b0, 2'b01, Z, 64'h0A, 4'b0100));
        tbl.push_back(v(WRP, 64'h0C, RDH, Z, 1'b0, 2'b01, Z, 64'h0B, 4'b0000));
        tbl.push_back(v(IDL, Z, RDP, Z, 1'b0, 2'b01, Z, 64'h0C, 4'b0100));
        tbl.push_back(v(IDL, Z, HOE, Z, 1'b0, 2'b01, Z, 64'h0C, 4'b0000));
        // both write 0x020 same edge: port0 wins
        tbl.push_back(v(ALE, 64'h020, ALE, 64'h020, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(WRP, 64'h1111, WRP, 64'h2222, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(IDL, Z, ALE, 64'h020, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(IDL, Z, RDP, Z, 1'b0, 2'b01, Z, 64'h1111, 4'b0100));
        tbl.push_back(v(IDL, Z, IDL, Z, 1'b0, 2'b00, Z, Z, 4'b0000));
        // read-before-write at 0x030
        tbl.push_back(v(ALE, 64'h030, ALE, 64'h030, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(WRP, 64'h44, IDL, Z, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(ALE, 64'h030, IDL, Z, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(WRP, 64'h55, RDP, Z, 1'b0, 2'b01, Z, 64'h44, 4'b0100));
        tbl.push_back(v(IDL, Z, ALE, 64'h030, 1'b0, 2'b01, Z, 64'h44, 4'b0000));
        tbl.push_back(v(IDL, Z, RDP, Z, 1'b0, 2'b01, Z, 64'h55, 4'b0100));
        // address wrap 0x3FF -> 0x000
        tbl.push_back(v(ALE, 64'h3FF, ALE, 64'h000, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(WRP, 64'hD1, IDL, Z, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(WRP, 64'hD2, IDL, Z, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(ALE, 64'h3FF, RDP, Z, 1'b0, 2'b01, Z, 64'hD2, 4'b0100));
        tbl.push_back(v(RDP, Z, IDL, Z, 1'b0, 2'b10, 64'hD1, Z, 4'b1000));
        tbl.push_back(v(RDP, Z, IDL, Z, 1'b0, 2'b10, 64'hD2, Z, 4'b1000));
        tbl.push_back(v(IDL, Z, IDL, Z, 1'b0, 2'b10, 64'hD2, Z, 4'b0000));
        // protocol errors
        tbl.push_back(v(ALE, 64'h040, ALE, 64'h041, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(WRP, 64'h77, WRP, 64'h99, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(IDL, Z, WRP, 64'h9A, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(WRP, 64'hEE, IDL, Z, 1'b0, 2'b00, Z, Z, 4'b0010));
        tbl.push_back(v(IDL, Z, ALE, 64'h041, 1'b0, 2'b00, Z, Z, 4'b0010));
        tbl.push_back(v(ALE, 64'h041, RDP, Z, 1'b0, 2'b01, Z, 64'h99, 4'b0100));
        tbl.push_back(v(RDP, Z, RDP, Z, 1'b0, 2'b11, 64'h99, 64'h9A, 4'b1100));
        tbl.push_back(v(WRP, 64'hEF, IDL, Z, 1'b0, 2'b10, 64'h99, Z, 4'b0010));
        tbl.push_back(v(IDL, Z, ALE, 64'h042, 1'b0, 2'b00, Z, Z, 4'b0010));
        tbl.push_back(v(ALE, 64'h000, RDP, Z, 1'b0, 2'b01, Z, 64'h9A, 4'b0100));
        tbl.push_back(v(WRP, 64'hD3, IDL, Z, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(RDP, Z, IDL, Z, 1'b0, 2'b10, 64'h99, Z, 4'b0010));
        // reset mid-burst
        tbl.push_back(v(ALE, 64'h010, ALE, 64'h010, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(RDP, Z, RDP, Z, 1'b0, 2'b11, 64'h0A, 64'h0A, 4'b1100));
        tbl.push_back(v(RDP, Z, RDP, Z, 1'b1, 2'b11, Z, Z, 4'b0000));
        tbl.push_back(v(RDP, Z, RDP, Z, 1'b1, 2'b11, Z, Z, 4'b0000));
        tbl.push_back(v(RDP, Z, RDP, Z, 1'b0, 2'b11, Z, Z, 4'b0011));
        tbl.push_back(v(ALE, 64'h010, ALE, 64'h011, 1'b0, 2'b00, Z, Z, 4'b0000));
        tbl.push_back(v(RDP, Z, RDP, Z, 1'b0, 2'b11, 64'h0A, 64'h0B, 4'b1100));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Address held in ADDR for several idle cycles, then a two-word read burst.
        apply(v(ALE, 64'h040, IDL, Z, 1'b0, 2'b00, Z, Z, 4'b0000), 100);
        for (int i = 0; i < 5; i++) begin
            apply(v(IDL, Z, IDL, Z, 1'b0, 2'b10, 64'h0A, Z, 4'b0000), 101 + i);
        end
        apply(v(RDP, Z, IDL, Z, 1'b0, 2'b10, 64'h77, Z, 4'b1000), 106);
        apply(v(RDP, Z, IDL, Z, 1'b0, 2'b10, 64'h99, Z, 4'b1000), 107);
        apply(v(IDL, Z, IDL, Z, 1'b0, 2'b10, 64'h99, Z, 4'b0000), 108);

        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d expected 0/0", q0.size(), q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
